// File: rtl/enigma_pkg.sv
// Shared definitions for the Enigma datapath: ASCII constants used by the
// output formatter and the transmit handshake state type.
package enigma_pkg;

    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Highest valid letter index ('Z')
    localparam logic [4:0] IDX_MAX = 5'd25;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } tx_state_t;

endpackage

// File: rtl/fifo_sincron.sv
// Synchronous FIFO: registered read data, power-of-2 depth, pointers wrap
// modulo DEPTH and an extra count bit separates full from empty.
module fifo_sincron #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // Full is judged on the current count, so a write while full is dropped
    // even if a pop happens in the same cycle.
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, count and registered read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/formatare_iesire_tx.sv
// Output formatter between the Enigma core and the UART transmitter.
// Buffers letter indices, converts them to ASCII and drives the
// tx_start/tx_din handshake. Define FORMATARE_GRUPARE_EN to insert a space
// every GROUP_LEN letters, CR LF every GROUPS_PER_LINE groups, and to honour
// flush; otherwise letters go out back-to-back and flush is ignored.
module formatare_iesire_tx
    import enigma_pkg::*;
#(
    parameter int DEPTH           = 16,
    parameter int GROUP_LEN       = 5,
    parameter int GROUPS_PER_LINE = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     char_valid,
    input  logic [4:0]               char_idx,
    input  logic                     flush,
    input  logic                     tx_active,
    input  logic                     tx_done,
    output logic                     tx_start,
    output logic [7:0]               tx_din,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_full,
    output logic                     overflow
);

    tx_state_t  state, state_n;
    logic [7:0] byte_q, byte_n;
    logic       sel_letter, sel_letter_n;
    logic       pop;
    logic       fifo_wr;
    logic       fifo_empty;
    logic [4:0] fifo_rd_data;

`ifdef FORMATARE_GRUPARE_EN
    localparam int LW = $clog2(GROUP_LEN + 1);
    localparam int GW = (GROUPS_PER_LINE > 1) ? $clog2(GROUPS_PER_LINE) : 1;

    logic [LW-1:0] letter_cnt, letter_cnt_n;
    logic [GW-1:0] group_cnt, group_cnt_n;
    logic          lf_pend, lf_pend_n;
    logic          flush_pend, flush_pend_n;
`else
    logic          unused_flush;
    assign unused_flush = flush;
`endif

    assign fifo_wr = char_valid && (char_idx <= IDX_MAX);

    fifo_sincron #(
        .WIDTH (5),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr),
        .wr_data (char_idx),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // The FIFO read data lands one edge after the pop, together with the
    // START state, so letters are converted from rd_data directly rather
    // than copied into byte_q; rd_data only moves on the next pop.
    assign tx_din   = sel_letter ? ({3'b000, fifo_rd_data} + ASCII_A) : byte_q;
    assign tx_start = (state == ST_START);

    // Sticky record of a letter dropped because the FIFO was full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (fifo_wr && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    // FSM, byte select and grouping state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            byte_q     <= '0;
            sel_letter <= 1'b0;
`ifdef FORMATARE_GRUPARE_EN
            letter_cnt <= '0;
            group_cnt  <= '0;
            lf_pend    <= 1'b0;
            flush_pend <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            byte_q     <= byte_n;
            sel_letter <= sel_letter_n;
`ifdef FORMATARE_GRUPARE_EN
            letter_cnt <= letter_cnt_n;
            group_cnt  <= group_cnt_n;
            lf_pend    <= lf_pend_n;
            flush_pend <= flush_pend_n;
`endif
        end
    end

    // Next-state logic: pick the next byte by priority when the line is free
    always_comb begin
        state_n      = state;
        byte_n       = byte_q;
        sel_letter_n = sel_letter;
        pop          = 1'b0;
`ifdef FORMATARE_GRUPARE_EN
        letter_cnt_n = letter_cnt;
        group_cnt_n  = group_cnt;
        lf_pend_n    = lf_pend;
        flush_pend_n = flush_pend | flush;
`endif
        case (state)
            ST_IDLE: begin
                if (!tx_active) begin
`ifdef FORMATARE_GRUPARE_EN
                    if (lf_pend) begin
                        byte_n       = ASCII_LF;
                        sel_letter_n = 1'b0;
                        lf_pend_n    = 1'b0;
                        state_n      = ST_START;
                    end else if (!fifo_empty && (letter_cnt == LW'(GROUP_LEN))) begin
                        sel_letter_n = 1'b0;
                        letter_cnt_n = '0;
                        state_n      = ST_START;
                        if (group_cnt == GW'(GROUPS_PER_LINE - 1)) begin
                            byte_n      = ASCII_CR;
                            lf_pend_n   = 1'b1;
                            group_cnt_n = '0;
                        end else begin
                            byte_n      = ASCII_SP;
                            group_cnt_n = group_cnt + GW'(1);
                        end
                    end else if (!fifo_empty) begin
                        pop          = 1'b1;
                        sel_letter_n = 1'b1;
                        letter_cnt_n = letter_cnt + LW'(1);
                        state_n      = ST_START;
                    end else if (flush_pend) begin
                        flush_pend_n = 1'b0;
                        if ((letter_cnt != '0) || (group_cnt != '0)) begin
                            byte_n       = ASCII_CR;
                            sel_letter_n = 1'b0;
                            lf_pend_n    = 1'b1;
                            letter_cnt_n = '0;
                            group_cnt_n  = '0;
                            state_n      = ST_START;
                        end
                    end
`else
                    if (!fifo_empty) begin
                        pop          = 1'b1;
                        sel_letter_n = 1'b1;
                        state_n      = ST_START;
                    end
`endif
                end
            end
            ST_START: begin
                state_n = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_formatare_iesire_tx.sv
// Directed self-checking bench for formatare_iesire_tx with a simple
// transmitter model (fixed-length bytes, tx_done with tx_active falling).
`timescale 1ns/1ps
module tb_formatare_iesire_tx;

`ifdef FORMATARE_GRUPARE_EN
    localparam bit GRP = 1'b1;
`else
    localparam bit GRP = 1'b0;
`endif
    localparam int DEPTH = 16;
    localparam int GL    = 5;
    localparam int GPL   = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       char_valid = 1'b0;
    logic [4:0] char_idx = '0;
    logic       flush = 1'b0;
    logic       tx_active;
    logic       tx_done = 1'b0;
    logic       tx_start;
    logic [7:0] tx_din;
    logic [$clog2(DEPTH):0] fifo_count;
    logic       fifo_full;
    logic       overflow;

    logic       model_active = 1'b0;
    logic       force_active = 1'b0;
    assign tx_active = model_active | force_active;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int valid_cyc = 0;
    int last_start_cyc = 0;
    int rst_epoch = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    formatare_iesire_tx #(
        .DEPTH           (DEPTH),
        .GROUP_LEN       (GL),
        .GROUPS_PER_LINE (GPL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char_valid (char_valid),
        .char_idx   (char_idx),
        .flush      (flush),
        .tx_active  (tx_active),
        .tx_done    (tx_done),
        .tx_start   (tx_start),
        .tx_din     (tx_din),
        .fifo_count (fifo_count),
        .fifo_full  (fifo_full),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transmitter model: captures each started byte, busy for a few cycles
    initial begin
        logic [7:0] cap;
        int ep;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                if (tx_active) check("start_while_busy", 1, 0);
                cap = tx_din;
                ep  = rst_epoch;
                rx_q.push_back(cap);
                last_start_cyc = cyc;
                model_active = 1'b1;
                repeat (3) @(negedge clk);
                tx_done      = 1'b1;
                model_active = 1'b0;
                if (ep == rst_epoch) check("din_hold", tx_din, cap);
                @(negedge clk);
                tx_done = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rst_epoch++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic push(input logic [4:0] idx);
        @(negedge clk);
        char_valid = 1'b1;
        char_idx   = idx;
        valid_cyc  = cyc;
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int quiet = 0;
        int n = 0;
        while (quiet < 10 && n < maxc) begin
            @(negedge clk);
            n++;
            if (fifo_count == 0 && !tx_active && !tx_start) quiet++;
            else quiet = 0;
        end
        check("drain_in_time", n < maxc, 1);
    endtask

    // Reference stream for letters first..first+n-1 sent from a fresh line
    function automatic void build_exp(input int first, input int n, input bit do_flush);
        int lc = 0;
        int gc = 0;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            if (GRP && lc == GL) begin
                if (gc == GPL - 1) begin
                    exp_q.push_back(8'h0D);
                    exp_q.push_back(8'h0A);
                    gc = 0;
                end else begin
                    exp_q.push_back(8'h20);
                    gc++;
                end
                lc = 0;
            end
            exp_q.push_back(8'(8'h41 + first + i));
            lc++;
        end
        if (do_flush && GRP && (lc != 0 || gc != 0)) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endfunction

    task automatic compare_stream(input string tag);
        int n;
        check({tag, "_len"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int starts;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_din", tx_din, 8'h00);
        check("rst_count", fifo_count, 0);
        check("rst_full", fifo_full, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single letter 'H' with latency check
        rx_q.delete();
        push(5'd7);
        drain(200);
        build_exp(7, 1, 1'b0);
        compare_stream("single");
        check("latency", last_start_cyc - valid_cyc, 2);

        // 26 letters paced slower than the transmitter
        do_reset();
        rx_q.delete();
        for (int i = 0; i < 26; i++) begin
            push(5'(i));
            repeat (5) @(negedge clk);
        end
        drain(2000);
        build_exp(0, 26, 1'b0);
        compare_stream("alpha");
        check("alpha_overflow", overflow, 0);

        // Flush after three letters, then flush with nothing pending
        do_reset();
        rx_q.delete();
        push(5'd0);
        push(5'd1);
        push(5'd2);
        pulse_flush();
        drain(500);
        build_exp(0, 3, 1'b1);
        compare_stream("flush");
        rx_q.delete();
        pulse_flush();
        drain(500);
        check("flush2_len", rx_q.size(), 0);

        // Out-of-range index is discarded silently
        rx_q.delete();
        push(5'd30);
        check("invalid_count", fifo_count, 0);
        drain(200);
        check("invalid_len", rx_q.size(), 0);
        check("invalid_overflow", overflow, 0);

        // Overflow with the transmitter held busy
        do_reset();
        rx_q.delete();
        force_active = 1'b1;
        for (int i = 0; i < 18; i++) push(5'(i));
        check("ovf_full", fifo_full, 1);
        check("ovf_count", fifo_count, DEPTH);
        check("ovf_flag", overflow, 1);
        check("ovf_no_start", rx_q.size(), 0);
        force_active = 1'b0;
        drain(2000);
        build_exp(0, DEPTH, 1'b0);
        compare_stream("ovf");
        check("ovf_sticky", overflow, 1);

        // Reset while a byte is in flight and the transmitter stays busy
        do_reset();
        push(5'd0);
        push(5'd1);
        push(5'd2);
        n = 0;
        while (!model_active && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_reach_busy", model_active, 1);
        force_active = 1'b1;
        rst_n = 1'b0;
        rst_epoch++;
        @(negedge clk);
        rx_q.delete();
        check("mid_tx_start", tx_start, 0);
        check("mid_tx_din", tx_din, 8'h00);
        check("mid_count", fifo_count, 0);
        check("mid_full", fifo_full, 0);
        check("mid_overflow", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        starts = 0;
        repeat (12) begin
            @(negedge clk);
            if (tx_start) starts++;
        end
        check("mid_no_start_busy", starts, 0);
        force_active = 1'b0;
        drain(500);
        check("mid_fifo_empty", fifo_count, 0);
        check("mid_no_bytes", rx_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/formatare_iesire_tx.md
# formatare_iesire_tx

Output formatter and buffer between the Enigma core's `char_out`/`valid_out` and the UART transmitter.
- Buffers 0–25 letter indices in a FIFO, converts them to ASCII 'A'–'Z' and drives the `tx_start`/`tx_din` handshake one byte at a time.
- Optionally inserts classic Enigma grouping separators: space every 5 letters, CR LF every 5 groups.
- Guarantees no byte is lost while the transmitter is busy, up to FIFO depth.

## Interface
- `DEPTH`, 16: FIFO entries; power of 2, ≥ 4.
- `GROUP_LEN`, 5: letters per group.
- `GROUPS_PER_LINE`, 5: groups per output line.
- `clk`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `char_valid`  in  1  one-cycle strobe; `char_idx` valid.
- `char_idx`  in  5  letter index, 0 = 'A'.
- `flush`  in  1  one-cycle strobe; terminate current line.
- `tx_active`  in  1  transmitter busy.
- `tx_done`  in  1  one-cycle strobe; byte finished.
- `tx_start`  out  1  one-cycle start strobe to transmitter.
- `tx_din`  out  8  ASCII byte to transmit.
- `fifo_count`  out  $clog2(DEPTH)+1  entries currently stored.
- `fifo_full`  out  1  `fifo_count == DEPTH`.
- `overflow`  out  1  sticky; a letter was dropped.

## Operation
- **Write rule:** on `char_valid` with `char_idx` ≤ 25:
  - If not full, push the index.
  - If full, drop the letter and set `overflow`.
  - Full is evaluated before any same-cycle pop, so a write while full is dropped even if a pop occurs that cycle.
- **Out-of-range indices:** `char_idx` 26–31 are silently discarded; `overflow` is unchanged.
- **`overflow`:** cleared only by reset.
- **FSM states:** IDLE, START, WAIT_DONE.
  - **IDLE:** wait until `tx_active` = 0. Then select the next byte in priority order:
    1. Pending separator byte (LF after CR).
    2. Separator owed before the next letter, if the FIFO is non-empty.
    3. Letter popped from the FIFO.
    4. Flush CR.
    - If a byte is selected, load `tx_din` and go to START.
  - **START:** `tx_start` = 1 for exactly one cycle, then go to WAIT_DONE.
  - **WAIT_DONE:** wait for `tx_done`, then go to IDLE.
- **Letter conversion:** `tx_din` = `char_idx` + 8'h41, 8-bit arithmetic.
- **Counters:**
  - `letter_cnt` ranges 0..`GROUP_LEN` and increments after each letter is sent.
  - `group_cnt` ranges 0..`GROUPS_PER_LINE`-1.
- **Lazy separators:** a separator is sent only when a following letter is already in the FIFO, so no separator trails the last letter.
  - When `letter_cnt` == `GROUP_LEN` and the FIFO is non-empty:
    - If `group_cnt` == `GROUPS_PER_LINE`-1: send CR then LF, and zero both counters.
    - Otherwise: send 8'h20, zero `letter_cnt`, and increment `group_cnt`.
- **Flush:**
  - `flush` sets `flush_pend`.
  - When the FIFO is empty and `flush_pend` = 1:
    - If the line is non-empty (either counter ≠ 0): send CR LF and zero the counters.
    - In all cases, clear `flush_pend`.
  - A `flush` arriving while `flush_pend` = 1 has no additional effect.

## Timing
- **Reset values:**
  - Outputs: `tx_start` = 0, `tx_din` = 8'h00, `fifo_count` = 0, `fifo_full` = 0, `overflow` = 0.
  - Internals: FSM = IDLE, counters = 0, `flush_pend` = 0.
- **Latency, idle transmitter:** `char_valid` in cycle N gives `tx_start` high in cycle N+2.
- **Data hold:** `tx_din` is stable from the `tx_start` cycle until the cycle after `tx_done`.
- **Transmitter behaviour:** the transmitter is not reset by `rst_n`.
  - After reset mid-byte, the FSM stays in IDLE until `tx_active` falls.
  - No new `tx_start` is issued while `tx_active` = 1.
- **Simultaneous write and pop:** a write and a pop in the same cycle leave `fifo_count` unchanged (when not full).
- **Pointer wrap:** pointers wrap modulo `DEPTH`; the count bit width distinguishes full from empty.
- **Stray `tx_done`:** a `tx_done` received outside WAIT_DONE is ignored.

## Configuration
- `FORMATARE_GRUPARE_EN` defined:
  - Space/CR LF insertion and flush behave as described above.
- `FORMATARE_GRUPARE_EN` undefined:
  - Letters are sent back-to-back with no separators.
  - `flush` is ignored.
  - Counters and `flush_pend` are not synthesized.

## Structure
- **Shared package `enigma_pkg`:**
  - ASCII constants `ASCII_A` = 8'h41, `ASCII_SP` = 8'h20, `ASCII_CR` = 8'h0D, `ASCII_LF` = 8'h0A.
  - FSM state typedef.
- **Sub-module `fifo_sincron`:**
  - Parameterized width and depth, synchronous read, asynchronous active-low reset.
  - Exposes full, empty and count.
  - Instantiated with width 5.

## Test plan
- **Single letter:** reset, push index 7 with the transmitter modelled at 4-cycle bytes -> exactly one byte 8'h48 ('H'); `tx_start` asserted 2 cycles after `char_valid`.
- **Grouping:** with `FORMATARE_GRUPARE_EN`, push 26 letters 0..25 -> byte stream "ABCDE FGHIJ KLMNO PQRST UVWXY" CR LF "Z"; no trailing space.
- **Overflow:** hold `tx_active` = 1 and push 18 letters with `DEPTH` = 16 -> `fifo_full` = 1, `fifo_count` = 16, `overflow` = 1. After release, exactly 16 letters are sent, in order.
- **Flush:**
  - Push 3 letters, then `flush` -> "ABC" CR LF.
  - A second `flush` with the line empty -> no bytes.
- **Invalid input:** push index 30 -> no write, `overflow` stays 0, no `tx_start`.
- **Reset mid-byte:** assert `rst_n` low during WAIT_DONE while `tx_active` = 1 -> all outputs return to reset values; no `tx_start` until `tx_active` falls; the FIFO is empty afterwards.
